// File: rtl/rv_pkg.sv
// Shared RV32I decode constants, control payload and immediate generation.
package rv_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [1:0] WB_MEM = 2'b00;
   localparam logic [1:0] WB_ALU = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b11;

   // IMM_Z: formats without an immediate (R-type, unknown) carry zero
   typedef enum logic [2:0] {
      IMM_Z = 3'd0,
      IMM_I = 3'd1,
      IMM_S = 3'd2,
      IMM_B = 3'd3,
      IMM_J = 3'd4,
      IMM_U = 3'd5
   } immsel_e;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic       valid;
      logic       regwrite;
      logic       memrw;
      logic       asel;
      logic       bsel;
      logic       branch;
      logic       jump;
      logic       illegal;
      logic [1:0] wbsel;
      alu_op_e    alusel;
      logic [2:0] brfunct;
   } ctrl_t;

   // 32-bit sign-extended immediate for the selected format
   function automatic logic [31:0] gen_imm(input logic [31:0] ins, input immsel_e sel);
      logic [31:0] imm;
      case (sel)
         IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
         IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         IMM_U:   imm = {ins[31:12], 12'h000};
         default: imm = 32'h0000_0000;
      endcase
      return imm;
   endfunction

   // funct3/funct7[5] to ALU op; funct7[5] only matters for R-type add/sub and shifts right
   function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_r);
      alu_op_e op;
      case (f3)
         3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/regfile_wt.sv
// Register file: two combinational read ports with write-through, x0 hardwired to zero.
module regfile_wt #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32,
   localparam int unsigned RW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we_i,
   input  logic [RW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [RW-1:0]   raddr1_i,
   input  logic [RW-1:0]   raddr2_i,
   output logic [XLEN-1:0] rdata1_c,
   output logic [XLEN-1:0] rdata2_c
);

   logic [XLEN-1:0] regs_q [NREG];
   logic            wr_en;

   assign wr_en = we_i && (waddr_i != '0);

   // Storage: cleared on reset, written on the rising edge except for x0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // Read ports: x0 reads zero, a same-cycle write to the read index is forwarded
   always_comb begin
      rdata1_c = regs_q[raddr1_i];
      rdata2_c = regs_q[raddr2_i];
      if (wr_en && (waddr_i == raddr1_i)) rdata1_c = wdata_i;
      if (wr_en && (waddr_i == raddr2_i)) rdata2_c = wdata_i;
      if (raddr1_i == '0) rdata1_c = '0;
      if (raddr2_i == '0) rdata2_c = '0;
   end

endmodule

// File: rtl/decode_stage_hz.sv
// RV32I decode stage: control decode, immediates, register read, load-use detect, ID/EX register.
module decode_stage_hz
   import rv_pkg::*;
#(
   parameter int unsigned   XLEN     = 32,
   parameter int unsigned   NREG     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   localparam int unsigned  RW       = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            valid_d,
   input  logic [31:0]     instr_d,
   input  logic [XLEN-1:0] pc_d,
   input  logic [XLEN-1:0] pc4_d,
   input  logic            regwrite_w,
   input  logic [RW-1:0]   rd_w,
   input  logic [XLEN-1:0] result_w,
   output logic            load_use_o,
   output logic            valid_e,
   output logic            regwrite_e,
   output logic            memrw_e,
   output logic            asel_e,
   output logic            bsel_e,
   output logic            branch_e,
   output logic            jump_e,
   output logic            illegal_e,
   output logic [1:0]      wbsel_e,
   output logic [3:0]      alusel_e,
   output logic [2:0]      brfunct_e,
   output logic [XLEN-1:0] rd1_e,
   output logic [XLEN-1:0] rd2_e,
   output logic [XLEN-1:0] imm_e,
   output logic [XLEN-1:0] pc_e,
   output logic [XLEN-1:0] pc4_e,
   output logic [RW-1:0]   rd_e,
   output logic [RW-1:0]   rs1_e,
   output logic [RW-1:0]   rs2_e
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            f7b5;
   logic [RW-1:0]   rs1_d, rs2_d, rdi_d;
   logic [XLEN-1:0] rd1_d, rd2_d, imm_d;
   ctrl_t           ctrl_c;
   immsel_e         immsel_c;
   logic            uses_rs2_c;

   ctrl_t           ctrl_e_q, ctrl_e_d;
   logic [XLEN-1:0] rd1_e_q, rd1_e_d, rd2_e_q, rd2_e_d, imm_e_q, imm_e_d;
   logic [XLEN-1:0] pc_e_q, pc_e_d, pc4_e_q, pc4_e_d;
   logic [RW-1:0]   rd_e_q, rd_e_d, rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d;
   logic            bubble, load_en;

   assign opcode = instr_d[6:0];
   assign funct3 = instr_d[14:12];
   assign f7b5   = instr_d[30];
   assign rs1_d  = instr_d[15 +: RW];
   assign rs2_d  = instr_d[20 +: RW];
   assign rdi_d  = instr_d[7 +: RW];

   regfile_wt #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (regwrite_w),
      .waddr_i  (rd_w),
      .wdata_i  (result_w),
      .raddr1_i (rs1_d),
      .raddr2_i (rs2_d),
      .rdata1_c (rd1_d),
      .rdata2_c (rd2_d)
   );

   // Control decode by opcode; unknown opcodes raise illegal with every other control low
   always_comb begin
      ctrl_c       = '0;
      immsel_c     = IMM_Z;
      uses_rs2_c   = 1'b0;
      ctrl_c.valid = 1'b1;
      case (opcode)
         OPC_OP: begin
            ctrl_c.regwrite = 1'b1;
            ctrl_c.wbsel    = WB_ALU;
            ctrl_c.alusel   = alu_decode(funct3, f7b5, 1'b1);
            uses_rs2_c      = 1'b1;
         end
         OPC_OPIMM: begin
            ctrl_c.regwrite = 1'b1;
            ctrl_c.wbsel    = WB_ALU;
            ctrl_c.bsel     = 1'b1;
            ctrl_c.alusel   = alu_decode(funct3, f7b5, 1'b0);
            immsel_c        = IMM_I;
         end
         OPC_LOAD: begin
            ctrl_c.regwrite = 1'b1;
            ctrl_c.wbsel    = WB_MEM;
            ctrl_c.bsel     = 1'b1;
            immsel_c        = IMM_I;
         end
         OPC_STORE: begin
            ctrl_c.memrw = 1'b1;
            ctrl_c.bsel  = 1'b1;
            immsel_c     = IMM_S;
            uses_rs2_c   = 1'b1;
         end
         OPC_BRANCH: begin
            ctrl_c.branch  = 1'b1;
            ctrl_c.brfunct = funct3;
            ctrl_c.asel    = 1'b1;
            ctrl_c.bsel    = 1'b1;
            immsel_c       = IMM_B;
            uses_rs2_c     = 1'b1;
         end
         OPC_JAL: begin
            ctrl_c.regwrite = 1'b1;
            ctrl_c.jump     = 1'b1;
            ctrl_c.wbsel    = WB_PC4;
            ctrl_c.asel     = 1'b1;
            ctrl_c.bsel     = 1'b1;
            immsel_c        = IMM_J;
         end
         OPC_JALR: begin
            ctrl_c.regwrite = 1'b1;
            ctrl_c.jump     = 1'b1;
            ctrl_c.wbsel    = WB_PC4;
            ctrl_c.bsel     = 1'b1;
            immsel_c        = IMM_I;
         end
         OPC_LUI: begin
            ctrl_c.regwrite = 1'b1;
            ctrl_c.wbsel    = WB_ALU;
            ctrl_c.bsel     = 1'b1;
            ctrl_c.alusel   = ALU_PASSB;
            immsel_c        = IMM_U;
         end
         OPC_AUIPC: begin
            ctrl_c.regwrite = 1'b1;
            ctrl_c.wbsel    = WB_ALU;
            ctrl_c.asel     = 1'b1;
            ctrl_c.bsel     = 1'b1;
            immsel_c        = IMM_U;
         end
         default: begin
            ctrl_c.illegal = 1'b1;
         end
      endcase
   end

   assign imm_d = XLEN'($signed(gen_imm(instr_d, immsel_c)));

   // Load in E whose destination feeds this instruction; a flush kills the stall
   assign load_use_o = !flush_i && valid_d && ctrl_e_q.valid && ctrl_e_q.regwrite &&
                       (ctrl_e_q.wbsel == WB_MEM) && (rd_e_q != '0) &&
                       ((rd_e_q == rs1_d) || (uses_rs2_c && (rd_e_q == rs2_d)));

   // Next ID/EX contents: bubble on flush, load-use or invalid input, else decoded values
   always_comb begin
      bubble   = flush_i || load_use_o || !valid_d;
      load_en  = flush_i || !stall_i;
      ctrl_e_d = ctrl_c;
      rd1_e_d  = rd1_d;
      rd2_e_d  = rd2_d;
      imm_e_d  = imm_d;
      pc_e_d   = pc_d;
      pc4_e_d  = pc4_d;
      rd_e_d   = rdi_d;
      rs1_e_d  = rs1_d;
      rs2_e_d  = rs2_d;
      if (bubble) begin
         ctrl_e_d = '0;
         rd1_e_d  = '0;
         rd2_e_d  = '0;
         imm_e_d  = '0;
         pc_e_d   = '0;
         pc4_e_d  = '0;
         rd_e_d   = '0;
         rs1_e_d  = '0;
         rs2_e_d  = '0;
      end
   end

   // ID/EX register: flush overrides stall, stall holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_e_q <= '0;
         rd1_e_q  <= '0;
         rd2_e_q  <= '0;
         imm_e_q  <= '0;
         pc_e_q   <= RESET_PC;
         pc4_e_q  <= RESET_PC + XLEN'(4);
         rd_e_q   <= '0;
         rs1_e_q  <= '0;
         rs2_e_q  <= '0;
      end else if (load_en) begin
         ctrl_e_q <= ctrl_e_d;
         rd1_e_q  <= rd1_e_d;
         rd2_e_q  <= rd2_e_d;
         imm_e_q  <= imm_e_d;
         pc_e_q   <= pc_e_d;
         pc4_e_q  <= pc4_e_d;
         rd_e_q   <= rd_e_d;
         rs1_e_q  <= rs1_e_d;
         rs2_e_q  <= rs2_e_d;
      end
   end

   assign valid_e    = ctrl_e_q.valid;
   assign regwrite_e = ctrl_e_q.regwrite;
   assign memrw_e    = ctrl_e_q.memrw;
   assign asel_e     = ctrl_e_q.asel;
   assign bsel_e     = ctrl_e_q.bsel;
   assign branch_e   = ctrl_e_q.branch;
   assign jump_e     = ctrl_e_q.jump;
   assign illegal_e  = ctrl_e_q.illegal;
   assign wbsel_e    = ctrl_e_q.wbsel;
   assign alusel_e   = ctrl_e_q.alusel;
   assign brfunct_e  = ctrl_e_q.brfunct;
   assign rd1_e      = rd1_e_q;
   assign rd2_e      = rd2_e_q;
   assign imm_e      = imm_e_q;
   assign pc_e       = pc_e_q;
   assign pc4_e      = pc4_e_q;
   assign rd_e       = rd_e_q;
   assign rs1_e      = rs1_e_q;
   assign rs2_e      = rs2_e_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed scoreboard bench for decode_stage_hz.
module tb_decode_stage_hz;

   typedef struct packed {
      logic        valid;
      logic        regwrite;
      logic        memrw;
      logic        asel;
      logic        bsel;
      logic        branch;
      logic        jump;
      logic        illegal;
      logic [1:0]  wbsel;
      logic [3:0]  alusel;
      logic [2:0]  brfunct;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i, flush_i, valid_d;
   logic [31:0] instr_d, pc_d, pc4_d;
   logic        regwrite_w;
   logic [4:0]  rd_w;
   logic [31:0] result_w;
   logic        load_use_o;
   logic        valid_e, regwrite_e, memrw_e, asel_e, bsel_e, branch_e, jump_e, illegal_e;
   logic [1:0]  wbsel_e;
   logic [3:0]  alusel_e;
   logic [2:0]  brfunct_e;
   logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
   logic [4:0]  rd_e, rs1_e, rs2_e;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q [$];
   string tag_q [$];
   exp_t e;

   always #5 clk = ~clk;

   decode_stage_hz #(
      .XLEN     (32),
      .NREG     (32),
      .RESET_PC (32'h0000_0080)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall_i    (stall_i),
      .flush_i    (flush_i),
      .valid_d    (valid_d),
      .instr_d    (instr_d),
      .pc_d       (pc_d),
      .pc4_d      (pc4_d),
      .regwrite_w (regwrite_w),
      .rd_w       (rd_w),
      .result_w   (result_w),
      .load_use_o (load_use_o),
      .valid_e    (valid_e),
      .regwrite_e (regwrite_e),
      .memrw_e    (memrw_e),
      .asel_e     (asel_e),
      .bsel_e     (bsel_e),
      .branch_e   (branch_e),
      .jump_e     (jump_e),
      .illegal_e  (illegal_e),
      .wbsel_e    (wbsel_e),
      .alusel_e   (alusel_e),
      .brfunct_e  (brfunct_e),
      .rd1_e      (rd1_e),
      .rd2_e      (rd2_e),
      .imm_e      (imm_e),
      .pc_e       (pc_e),
      .pc4_e      (pc4_e),
      .rd_e       (rd_e),
      .rs1_e      (rs1_e),
      .rs2_e      (rs2_e)
   );

   function automatic exp_t sample();
      exp_t s;
      s = '{valid_e, regwrite_e, memrw_e, asel_e, bsel_e, branch_e, jump_e, illegal_e,
            wbsel_e, alusel_e, brfunct_e, rd1_e, rd2_e, imm_e, pc_e, pc4_e, rd_e, rs1_e, rs2_e};
      return s;
   endfunction

   function automatic exp_t base(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] imm);
      exp_t b;
      b       = '0;
      b.valid = 1'b1;
      b.pc    = pc;
      b.pc4   = pc + 32'd4;
      b.rd    = rd;
      b.rs1   = rs1;
      b.rs2   = rs2;
      b.rd1   = r1;
      b.rd2   = r2;
      b.imm   = imm;
      return b;
   endfunction

   task automatic drive(input logic [31:0] ins, input logic v, input logic [31:0] pc);
      instr_d = ins;
      valid_d = v;
      pc_d    = pc;
      pc4_d   = pc + 32'd4;
   endtask

   task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
      regwrite_w = we;
      rd_w       = rd;
      result_w   = data;
   endtask

   task automatic push(input string tag, input exp_t x);
      exp_q.push_back(x);
      tag_q.push_back(tag);
   endtask

   // Advance one clock and compare the ID/EX outputs against the oldest expectation
   task automatic cycle();
      exp_t  want, got;
      string tag;
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         tag  = tag_q.pop_front();
         got  = sample();
         checks++;
         assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
         end
      end
   endtask

   task automatic chk_lu(input string tag, input logic want);
      #1;
      checks++;
      assert (load_use_o === want) else begin
         errors++;
         $error("FAIL %s: observed load_use_o=%b expected %b", tag, load_use_o, want);
      end
   endtask

   task automatic chk_now(input string tag, input exp_t want);
      exp_t got;
      got = sample();
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      stall_i = 1'b0;
      flush_i = 1'b0;
      drive(32'h0000_0013, 1'b0, 32'h0);
      wb(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      e = '0; e.pc = 32'h80; e.pc4 = 32'h84;
      chk_now("reset_state", e);
      rst_n = 1'b1;

      // addi x1,x0,-5
      drive(32'hFFB0_0093, 1'b1, 32'h100);
      e = base(32'h100, 5'd1, 5'd0, 5'd27, 32'h0, 32'h0, 32'hFFFF_FFFB);
      e.regwrite = 1'b1; e.wbsel = 2'b01; e.bsel = 1'b1;
      push("addi", e);
      cycle();

      // add x2,x1,x1 with a same-cycle writeback of x1
      drive(32'h0010_8133, 1'b1, 32'h104);
      wb(1'b1, 5'd1, 32'h1234);
      e = base(32'h104, 5'd2, 5'd1, 5'd1, 32'h1234, 32'h1234, 32'h0);
      e.regwrite = 1'b1; e.wbsel = 2'b01;
      push("add_wt", e);
      cycle();
      wb(1'b0, 5'd0, 32'h0);

      // lw x3,0(x2)
      drive(32'h0001_2183, 1'b1, 32'h108);
      chk_lu("lu_before_lw", 1'b0);
      e = base(32'h108, 5'd3, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0);
      e.regwrite = 1'b1; e.wbsel = 2'b00; e.bsel = 1'b1;
      push("lw", e);
      cycle();

      // add x4,x3,x0 behind the load: one bubble, then it issues
      drive(32'h0001_8233, 1'b1, 32'h10C);
      chk_lu("lu_hit", 1'b1);
      push("lu_bubble", '0);
      cycle();
      chk_lu("lu_released", 1'b0);
      e = base(32'h10C, 5'd4, 5'd3, 5'd0, 32'h0, 32'h0, 32'h0);
      e.regwrite = 1'b1; e.wbsel = 2'b01;
      push("add_after_lu", e);
      cycle();

      // beq x1,x2,-8
      drive(32'hFE20_8CE3, 1'b1, 32'h110);
      e = base(32'h110, 5'd25, 5'd1, 5'd2, 32'h1234, 32'h0, 32'hFFFF_FFF8);
      e.branch = 1'b1; e.asel = 1'b1; e.bsel = 1'b1; e.brfunct = 3'b000;
      push("beq", e);
      cycle();

      // sub x10,x1,x2
      drive(32'h4020_8533, 1'b1, 32'h114);
      e = base(32'h114, 5'd10, 5'd1, 5'd2, 32'h1234, 32'h0, 32'h0);
      e.regwrite = 1'b1; e.wbsel = 2'b01; e.alusel = 4'd1;
      push("sub", e);
      cycle();

      // srai x11,x1,3
      drive(32'h4030_D593, 1'b1, 32'h118);
      e = base(32'h118, 5'd11, 5'd1, 5'd3, 32'h1234, 32'h0, 32'h0000_0403);
      e.regwrite = 1'b1; e.wbsel = 2'b01; e.bsel = 1'b1; e.alusel = 4'd7;
      push("srai", e);
      cycle();

      // sw x1,4(x2)
      drive(32'h0011_2223, 1'b1, 32'h11C);
      e = base(32'h11C, 5'd4, 5'd2, 5'd1, 32'h0, 32'h1234, 32'h4);
      e.memrw = 1'b1; e.bsel = 1'b1;
      push("sw", e);
      cycle();

      // invalid slot becomes a bubble
      drive(32'hFFB0_0093, 1'b0, 32'h120);
      push("valid_low", '0);
      cycle();

      // lui x5,0x12345
      drive(32'h1234_52B7, 1'b1, 32'h124);
      e = base(32'h124, 5'd5, 5'd8, 5'd3, 32'h0, 32'h0, 32'h1234_5000);
      e.regwrite = 1'b1; e.wbsel = 2'b01; e.bsel = 1'b1; e.alusel = 4'd10;
      push("lui", e);
      cycle();

      // stall three cycles with changing input: E holds the lui
      stall_i = 1'b1;
      drive(32'hFFB0_0093, 1'b1, 32'h128);
      push("stall1", e);
      cycle();
      drive(32'hFE20_8CE3, 1'b1, 32'h12C);
      push("stall2", e);
      cycle();
      drive(32'h0000_007F, 1'b1, 32'h130);
      push("stall3", e);
      cycle();

      // flush beats stall
      flush_i = 1'b1;
      drive(32'hFFB0_0093, 1'b1, 32'h134);
      push("flush_over_stall", '0);
      cycle();
      flush_i = 1'b0;
      stall_i = 1'b0;

      // unknown opcode 0x7F, plus an attempted write to x0
      drive(32'h0000_007F, 1'b1, 32'h130);
      wb(1'b1, 5'd0, 32'hDEAD);
      e = base(32'h130, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      e.illegal = 1'b1;
      push("illegal", e);
      cycle();

      // add x7,x0,x0: x0 reads zero even with a same-cycle write to it
      drive(32'h0000_03B3, 1'b1, 32'h134);
      wb(1'b1, 5'd0, 32'hBEEF);
      e = base(32'h134, 5'd7, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      e.regwrite = 1'b1; e.wbsel = 2'b01;
      push("x0_zero", e);
      cycle();
      wb(1'b0, 5'd0, 32'h0);

      // jal x1,8
      drive(32'h0080_00EF, 1'b1, 32'h138);
      e = base(32'h138, 5'd1, 5'd0, 5'd8, 32'h0, 32'h0, 32'h8);
      e.regwrite = 1'b1; e.jump = 1'b1; e.wbsel = 2'b11; e.asel = 1'b1; e.bsel = 1'b1;
      push("jal", e);
      cycle();

      // write x5 and read it back, then reset mid-run
      drive(32'h0052_84B3, 1'b1, 32'h13C);
      wb(1'b1, 5'd5, 32'h55);
      e = base(32'h13C, 5'd9, 5'd5, 5'd5, 32'h55, 32'h55, 32'h0);
      e.regwrite = 1'b1; e.wbsel = 2'b01;
      push("x5_write", e);
      cycle();
      wb(1'b0, 5'd0, 32'h0);
      rst_n = 1'b0;
      #1;
      e = '0; e.pc = 32'h80; e.pc4 = 32'h84;
      chk_now("reset_mid_run", e);
      @(negedge clk);
      rst_n = 1'b1;
      drive(32'h0052_84B3, 1'b1, 32'h140);
      e = base(32'h140, 5'd9, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0);
      e.regwrite = 1'b1; e.wbsel = 2'b01;
      push("x5_after_reset", e);
      cycle();

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed %0d left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
